// File: rtl/adpll_tdc_pkg.sv
// Shared widths, FSM encoding and the rounding helper for the ADPLL TDC front end.
package adpll_tdc_pkg;

  localparam int CNTW  = 7;
  localparam int PHW   = 16;
  localparam int FRACB = 4;
  localparam int OUTW  = 12;
  localparam int PW    = CNTW + FRACB;
  localparam int ROUND = 8;

  localparam int MAX_INC_DEF      = 200;
  localparam int PRIME_CYCLES_DEF = 2;
  localparam int GLITCH_LIMIT_DEF = 3;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } tdc_state_e;

  // Round a composite-phase delta (FRACB fractional bits) to whole DCO cycles.
  function automatic logic [OUTW-1:0] round_inc(input logic [PW-1:0] d);
    logic [PW:0] s;
    s = {1'b0, d} + (PW+1)'(ROUND);
    return OUTW'(s >> FRACB);
  endfunction

endpackage

// File: rtl/thermo_dec.sv
// Thermometer phase to FRACB-bit fraction, saturated.
// TDC_BUBBLE_FIX_EN selects popcount (bubble tolerant) over first-zero priority encode.
module thermo_dec
  import adpll_tdc_pkg::*;
(
  input  logic [PHW-1:0]   phase_i,
  output logic [FRACB-1:0] frac_o
);

  localparam int CW = $clog2(PHW + 1);

  logic [CW-1:0] cnt;

`ifdef TDC_BUBBLE_FIX_EN
  always_comb begin
    cnt = '0;
    for (int i = 0; i < PHW; i++) begin
      if (phase_i[i]) cnt = cnt + CW'(1);
    end
  end
`else
  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < PHW; i++) begin
      if (run && phase_i[i]) cnt = cnt + CW'(1);
      else                   run = 1'b0;
    end
  end
`endif

  assign frac_o = (cnt[CW-1:FRACB] != '0) ? '1 : cnt[FRACB-1:0];

endmodule

// File: rtl/tdc_word_gen.sv
// TDC word generator: samples ripple count and thermometer phase on posedge,
// publishes the rounded per-period increment on the following negedge.
module tdc_word_gen
  import adpll_tdc_pkg::*;
#(
  parameter int MAX_INC      = MAX_INC_DEF,
  parameter int PRIME_CYCLES = PRIME_CYCLES_DEF,
  parameter int GLITCH_LIMIT = GLITCH_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [CNTW-1:0] counter_in,
  input  logic [PHW-1:0]  phase_in,
  output logic [OUTW-1:0] tdc_word,
  output logic            tdc_valid,
  output logic            tdc_err,
  output logic [7:0]      glitch_cnt,
  output logic            dbg_state
);

  // Posedge sample domain
  logic [CNTW-1:0] cnt_q;
  logic [PHW-1:0]  ph_q;
  logic            sample_q, en_prev_q, restart_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ph_q      <= '0;
      sample_q  <= 1'b0;
      en_prev_q <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      sample_q  <= en;
      en_prev_q <= en;
      restart_q <= en & ~en_prev_q;
      if (en) begin
        cnt_q <= counter_in;
        ph_q  <= phase_in;
      end
    end
  end

  logic [FRACB-1:0] frac;
  logic [PW-1:0]    p_cur;
  logic [OUTW-1:0]  inc;

  thermo_dec u_thermo_dec (
    .phase_i (ph_q),
    .frac_o  (frac)
  );

  // Negedge publish domain
  tdc_state_e      state_q, state_d;
  logic [7:0]      prime_q, prime_d, prime_nxt;
  logic [7:0]      consec_q, consec_d, consec_nxt;
  logic [PW-1:0]   pprev_q, pprev_d;
  logic [OUTW-1:0] word_q, word_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      gcnt_q, gcnt_d;

  // Modular subtraction absorbs a single ripple-counter wrap.
  assign p_cur = {cnt_q, frac};
  assign inc   = round_inc(p_cur - pprev_q);

  always_comb begin
    state_d    = state_q;
    prime_d    = prime_q;
    consec_d   = consec_q;
    pprev_d    = pprev_q;
    word_d     = word_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    gcnt_d     = gcnt_q;
    prime_nxt  = prime_q + 8'd1;
    consec_nxt = consec_q + 8'd1;
    if (sample_q) begin
      pprev_d = p_cur;
      if (restart_q || state_q == PRIME) begin
        if (restart_q) prime_nxt = 8'd1;
        valid_d  = 1'b0;
        consec_d = '0;
        if (prime_nxt >= 8'(PRIME_CYCLES)) begin
          state_d = RUN;
          prime_d = '0;
        end else begin
          state_d = PRIME;
          prime_d = prime_nxt;
        end
      end else if (inc <= OUTW'(MAX_INC)) begin
        word_d   = inc;
        valid_d  = 1'b1;
        consec_d = '0;
      end else begin
        err_d = 1'b1;
        if (gcnt_q != 8'hFF) gcnt_d = gcnt_q + 8'd1;
        if (consec_nxt >= 8'(GLITCH_LIMIT)) begin
          state_d  = PRIME;
          valid_d  = 1'b0;
          consec_d = '0;
          prime_d  = '0;
        end else begin
          consec_d = consec_nxt;
        end
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PRIME;
      prime_q  <= '0;
      consec_q <= '0;
      pprev_q  <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      prime_q  <= prime_d;
      consec_q <= consec_d;
      pprev_q  <= pprev_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign tdc_word   = word_q;
  assign tdc_valid  = valid_q;
  assign tdc_err    = err_q & en;
  assign glitch_cnt = gcnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tdc_word_gen.sv
// Directed-vector bench for tdc_word_gen; glitch threshold lowered to 100 so
// glitches are reachable with an 11-bit composite phase.
module tb_tdc_word_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [6:0]  counter_in;
  logic [15:0] phase_in;
  logic [11:0] tdc_word;
  logic        tdc_valid;
  logic        tdc_err;
  logic [7:0]  glitch_cnt;
  logic        dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  tdc_word_gen #(.MAX_INC(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .counter_in (counter_in),
    .phase_in   (phase_in),
    .tdc_word   (tdc_word),
    .tdc_valid  (tdc_valid),
    .tdc_err    (tdc_err),
    .glitch_cnt (glitch_cnt),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [6:0]  cnt;
    logic [15:0] ph;
    logic [11:0] w;
    logic        v;
    logic        e;
    logic [7:0]  g;
    logic        st;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [6:0] c, input logic [15:0] p);
    en = e;
    counter_in = c;
    phase_in = p;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] w, input logic v,
                         input logic e, input logic [7:0] g, input logic st);
    chk({tag, "_word"},  32'(tdc_word),   32'(w));
    chk({tag, "_valid"}, 32'(tdc_valid),  32'(v));
    chk({tag, "_err"},   32'(tdc_err),    32'(e));
    chk({tag, "_gcnt"},  32'(glitch_cnt), 32'(g));
    chk({tag, "_state"}, 32'(dbg_state),  32'(st));
  endtask

  initial begin
    logic [11:0] bub;
    logic [6:0]  c;
`ifdef TDC_BUBBLE_FIX_EN
    bub = 12'd10;
`else
    bub = 12'd9;
`endif
    //           en cnt   phase     word v  e  g  st
    vecs[0]  = '{1, 0,   16'h0000, 0,   0, 0, 0, 0};
    vecs[1]  = '{1, 0,   16'h00FF, 0,   0, 0, 0, 1};
    vecs[2]  = '{1, 75,  16'h0FFF, 75,  1, 0, 0, 1};
    vecs[3]  = '{1, 100, 16'h0000, 24,  1, 0, 0, 1};
    vecs[4]  = '{1, 47,  16'h0000, 75,  1, 0, 0, 1};
    vecs[5]  = '{1, 19,  16'h0000, 100, 1, 0, 0, 1};
    vecs[6]  = '{1, 119, 16'h00FF, 100, 1, 1, 1, 1};
    vecs[7]  = '{1, 1,   16'h00FF, 10,  1, 0, 1, 1};
    vecs[8]  = '{1, 113, 16'h00FF, 10,  1, 1, 2, 1};
    vecs[9]  = '{1, 97,  16'h00FF, 10,  1, 1, 3, 1};
    vecs[10] = '{1, 81,  16'h00FF, 10,  0, 1, 4, 0};
    vecs[11] = '{1, 91,  16'h00FF, 10,  0, 0, 4, 0};
    vecs[12] = '{1, 101, 16'h00FF, 10,  0, 0, 4, 1};
    vecs[13] = '{1, 121, 16'h00FF, 20,  1, 0, 4, 1};
    vecs[14] = '{1, 121, 16'h00FF, 0,   1, 0, 4, 1};
    vecs[15] = '{1, 121, 16'hFFFF, 0,   1, 0, 4, 1};
    vecs[16] = '{1, 3,   16'h00BF, bub, 1, 0, 4, 1};

    rst = 1'b1;
    en = 1'b0;
    counter_in = '0;
    phase_in = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en, vecs[i].cnt, vecs[i].ph);
      chk_all($sformatf("v%0d", i), vecs[i].w, vecs[i].v, vecs[i].e, vecs[i].g, vecs[i].st);
    end

    // Enable dropped while the counter keeps running: everything holds.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 7'(13 + 10 * i), 16'h0000);
      chk_all($sformatf("en_off%0d", i), bub, 1, 0, 4, 1);
    end
    step(1'b1, 63, 16'h00FF);
    chk_all("en_back0", bub, 0, 0, 4, 0);
    step(1'b1, 73, 16'h00FF);
    chk_all("en_back1", bub, 0, 0, 4, 1);
    step(1'b1, 83, 16'h00FF);
    chk_all("en_back2", 10, 1, 0, 4, 1);

    // Continuous oversize increments drive glitch_cnt into saturation.
    c = 7'd83;
    for (int i = 0; i < 450; i++) begin
      c = c + 7'd112;
      step(1'b1, c, 16'h00FF);
    end
    chk("gcnt_sat", 32'(glitch_cnt), 32'd255);
    chk("gcnt_sat_word", 32'(tdc_word), 32'd10);

    // Reset asserted between edges takes effect without a clock.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
